// File: rtl/sdram_host_sched.sv
// sdram_host_sched
//   Queues host read/write requests and hands them one at a time to an SDRAM
//   controller, interleaving periodic REFRESH commands. Refresh wins over a
//   queued request in the same IDLE cycle. Read data arrives as four bytes on
//   DATAOUT after R_DATAEND and is packed little-endian into RSP_RDATA.
//
// Optional feature:
//   SDRAM_HOST_SCHED_TIMEOUT_EN - when defined, a command that is not
//   accepted within ACK_TIMEOUT cycles is abandoned (host request completes
//   with RSP_ERR=1, refresh is silently dropped). When undefined the block
//   waits for CMDACK forever and RSP_ERR is constant 0.
//
// Ports:
//   CLK, RESET_N      clock; asynchronous reset, active HIGH despite the name
//   REQ_VALID/READY   host request handshake
//   REQ_WR/ADDR/WDATA host request fields (1 = write)
//   RSP_VALID         one-cycle completion pulse
//   RSP_RDATA/ERR     read data / ack-timeout flag qualifying RSP_VALID
//   CMD/ADDR/DATAIN   command to the controller (000 NOP, 001 READA,
//                     010 WRITEA, 011 REFRESH)
//   CMDACK            controller accepted the command
//   R_DATAEND/DATAOUT controller read completion and byte stream
module sdram_host_sched #(
    parameter int REFRESH_PERIOD = 1560,
    parameter int FIFO_DEPTH     = 4,
    parameter int WR_HOLD        = 12,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [2:0]  CMD,
    output logic [31:0] ADDR,
    output logic [31:0] DATAIN,
    input  logic        CMDACK,
    input  logic        R_DATAEND,
    input  logic [7:0]  DATAOUT
);

`ifdef SDRAM_HOST_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int HW = $clog2(WR_HOLD + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(WR_HOLD - 1);
    localparam logic [HW-1:0] HOLD_PULSE = HW'(WR_HOLD - 2);
    localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_READA   = 3'b001;
    localparam logic [2:0] CMD_WRITEA  = 3'b010;
    localparam logic [2:0] CMD_REFRESH = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WHOLD, S_RWAIT, S_RCAP, S_REFACK
    } state_t;

    state_t          state;
    logic [2:0]      cmd_r;
    logic [31:0]     addr_r;
    logic [31:0]     datain_r;
    logic            rsp_valid_r;
    logic [31:0]     rsp_rdata_r;
    logic            rsp_err_r;
    logic            cur_wr;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   to_cnt;
    logic [2:0]      cap_cnt;

    logic            fifo_wr   [FIFO_DEPTH];
    logic [31:0]     fifo_addr [FIFO_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            ready;
    logic            push;
    logic            pop;

    logic [RW-1:0]   ref_cnt;
    logic            ref_wrap;
    logic            ref_pending;
    logic            ref_clear;
    logic            timed_out;

    assign push      = REQ_VALID & ready;
    // The FSM takes the head entry only when no refresh is waiting.
    assign pop       = (state == S_IDLE) & ~ref_pending & (count != '0);
    assign ref_wrap  = (ref_cnt == REF_LAST);
    assign timed_out = TIMEOUT_EN & (to_cnt == TO_LAST);
    assign ref_clear = (state == S_REFACK) & (CMDACK | timed_out);

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // READY is registered from the next occupancy so it is low in reset and
    // rises on the first clock edge after reset is released.
    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            ready <= (count_next != DEPTH_C);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_wr[wr_ptr]   <= REQ_WR;
            fifo_addr[wr_ptr] <= REQ_ADDR;
            fifo_data[wr_ptr] <= REQ_WDATA;
        end
    end

    // Free-running refresh interval counter, independent of FSM state.
    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            state       <= S_IDLE;
            cmd_r       <= CMD_NOP;
            addr_r      <= '0;
            datain_r    <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            cur_wr      <= 1'b0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            cap_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (ref_pending) begin
                        cmd_r <= CMD_REFRESH;
                        state <= S_REFACK;
                    end else if (count != '0) begin
                        cmd_r    <= fifo_wr[rd_ptr] ? CMD_WRITEA : CMD_READA;
                        addr_r   <= fifo_addr[rd_ptr];
                        datain_r <= fifo_data[rd_ptr];
                        cur_wr   <= fifo_wr[rd_ptr];
                        state    <= S_ISSUE;
                    end else begin
                        cmd_r <= CMD_NOP;
                    end
                end
                S_ISSUE: begin
                    if (CMDACK) begin
                        cmd_r    <= CMD_NOP;
                        hold_cnt <= '0;
                        if (cur_wr) begin
                            // A one-cycle hold makes the first WHOLD cycle the last.
                            rsp_valid_r <= (WR_HOLD == 1);
                            state       <= S_WHOLD;
                        end else begin
                            state <= S_RWAIT;
                        end
                    end else if (timed_out) begin
                        cmd_r       <= CMD_NOP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_WHOLD: begin
                    // The pulse is registered one count early so it lines up
                    // with the final hold cycle.
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt    <= hold_cnt + HW'(1);
                        rsp_valid_r <= (hold_cnt == HOLD_PULSE);
                    end
                end
                S_RWAIT: begin
                    if (R_DATAEND) begin
                        cap_cnt <= '0;
                        state   <= S_RCAP;
                    end
                end
                S_RCAP: begin
                    // The first edge after R_DATAEND carries no data; bytes
                    // follow on the next four edges, least significant first.
                    cap_cnt <= cap_cnt + 3'd1;
                    case (cap_cnt)
                        3'd1: rsp_rdata_r[7:0]   <= DATAOUT;
                        3'd2: rsp_rdata_r[15:8]  <= DATAOUT;
                        3'd3: rsp_rdata_r[23:16] <= DATAOUT;
                        3'd4: begin
                            rsp_rdata_r[31:24] <= DATAOUT;
                            rsp_valid_r        <= 1'b1;
                            state              <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
                S_REFACK: begin
                    if (ref_clear) begin
                        cmd_r <= CMD_NOP;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new wrap outranks the clear so a refresh interval is never lost.
            if (ref_wrap) begin
                ref_pending <= 1'b1;
            end else if (ref_clear) begin
                ref_pending <= 1'b0;
            end
        end
    end

    assign REQ_READY = ready;
    assign CMD       = cmd_r;
    assign ADDR      = addr_r;
    assign DATAIN    = datain_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_RDATA = rsp_rdata_r;
    assign RSP_ERR   = TIMEOUT_EN ? rsp_err_r : 1'b0;

endmodule

// File: tb/tb_sdram_host_sched.sv
// tb_sdram_host_sched
//   Directed bench for sdram_host_sched. The main instance uses default
//   parameters; a second instance with REFRESH_PERIOD=8 shares the inputs
//   and is observed only in the refresh sequence.
module tb_sdram_host_sched;

    typedef struct {
        logic        reqValid;
        logic        reqWr;
        logic [31:0] reqAddr;
        logic        cmdAck;
        logic        rDataEnd;
        logic [7:0]  dataOut;
        logic [2:0]  expCmd;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqWr;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        cmdAck;
    logic        rDataEnd;
    logic [7:0]  dataOut;

    logic        reqReady,  rReqReady;
    logic        rspValid,  rRspValid;
    logic [31:0] rspRdata,  rRspRdata;
    logic        rspErr,    rRspErr;
    logic [2:0]  cmd,       rCmd;
    logic [31:0] addr,      rAddr;
    logic [31:0] datain,    rDatain;

    int testCount = 0;
    int failCount = 0;

    vec_t readVec [12];

    sdram_host_sched dut (
        .CLK(clk), .RESET_N(rst),
        .REQ_VALID(reqValid), .REQ_READY(reqReady), .REQ_WR(reqWr),
        .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
        .RSP_VALID(rspValid), .RSP_RDATA(rspRdata), .RSP_ERR(rspErr),
        .CMD(cmd), .ADDR(addr), .DATAIN(datain),
        .CMDACK(cmdAck), .R_DATAEND(rDataEnd), .DATAOUT(dataOut)
    );

    sdram_host_sched #(.REFRESH_PERIOD(8)) dutRef (
        .CLK(clk), .RESET_N(rst),
        .REQ_VALID(reqValid), .REQ_READY(rReqReady), .REQ_WR(reqWr),
        .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
        .RSP_VALID(rRspValid), .RSP_RDATA(rRspRdata), .RSP_ERR(rRspErr),
        .CMD(rCmd), .ADDR(rAddr), .DATAIN(rDatain),
        .CMDACK(cmdAck), .R_DATAEND(rDataEnd), .DATAOUT(dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reqValid = v.reqValid;
        reqWr    = v.reqWr;
        reqAddr  = v.reqAddr;
        reqWdata = 32'h0;
        cmdAck   = v.cmdAck;
        rDataEnd = v.rDataEnd;
        dataOut  = v.dataOut;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd"},    32'(cmd),      32'h0);
        checkOutput({tag, "_addr"},   addr,          32'h0);
        checkOutput({tag, "_datain"}, datain,        32'h0);
        checkOutput({tag, "_valid"},  32'(rspValid), 32'h0);
        checkOutput({tag, "_rdata"},  rspRdata,      32'h0);
        checkOutput({tag, "_err"},    32'(rspErr),   32'h0);
        checkOutput({tag, "_ready"},  32'(reqReady), 32'h0);
    endtask

    task automatic doReset;
        reqValid = 0; reqWr = 0; reqAddr = 0; reqWdata = 0;
        cmdAck = 0; rDataEnd = 0; dataOut = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        checkOutput("ready_after_reset", 32'(reqReady), 32'h1);
    endtask

    initial begin
        int pulses;
        int waited;
        int early;
        int badCycles;

        // Read transaction: inputs for each cycle, expected outputs after the edge.
        readVec[0]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 8'h00, 3'b000, 32'h00, 1'b0, 32'h0000_0000};
        readVec[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 3'b001, 32'h40, 1'b0, 32'h0000_0000};
        readVec[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 8'h00, 3'b000, 32'h40, 1'b0, 32'h0000_0000};
        readVec[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 3'b000, 32'h40, 1'b0, 32'h0000_0000};
        readVec[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 8'h00, 3'b000, 32'h40, 1'b0, 32'h0000_0000};
        readVec[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'h11, 3'b000, 32'h40, 1'b0, 32'h0000_0000};
        readVec[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'hEF, 3'b000, 32'h40, 1'b0, 32'h0000_00EF};
        readVec[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'hBE, 3'b000, 32'h40, 1'b0, 32'h0000_BEEF};
        readVec[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'hAD, 3'b000, 32'h40, 1'b0, 32'h00AD_BEEF};
        readVec[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'hDE, 3'b000, 32'h40, 1'b1, 32'hDEAD_BEEF};
        readVec[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 3'b000, 32'h40, 1'b0, 32'hDEAD_BEEF};
        readVec[11] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 8'h55, 3'b000, 32'h40, 1'b0, 32'hDEAD_BEEF};

        reqValid = 0; reqWr = 0; reqAddr = 0; reqWdata = 0;
        cmdAck = 0; rDataEnd = 0; dataOut = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 checkResetValues("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        checkOutput("ready_after_por", 32'(reqReady), 32'h1);

        // Write with a three-cycle ack delay, then the data hold window.
        reqValid = 1; reqWr = 1; reqAddr = 32'h0000_0123; reqWdata = 32'hDEAD_BEEF;
        tick;
        reqValid = 0;
        tick;
        checkOutput("wr_cmd",    32'(cmd), 32'h2);
        checkOutput("wr_addr",   addr,     32'h123);
        checkOutput("wr_datain", datain,   32'hDEAD_BEEF);
        tick;
        checkOutput("wr_cmd_hold1", 32'(cmd), 32'h2);
        tick;
        checkOutput("wr_cmd_hold2", 32'(cmd), 32'h2);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        checkOutput("wr_cmd_after_ack",   32'(cmd),      32'h0);
        checkOutput("wr_valid_after_ack", 32'(rspValid), 32'h0);
        pulses = 0;
        for (int i = 1; i <= 11; i++) begin
            tick;
            checkOutput("wr_datain_held", datain, 32'hDEAD_BEEF);
            checkOutput("wr_valid_pos", 32'(rspValid), 32'(i == 11));
            if (rspValid) pulses++;
            if (i == 11) checkOutput("wr_err", 32'(rspErr), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rspValid) pulses++;
        end
        checkOutput("wr_pulse_count", 32'(pulses), 32'h1);

        // Read, table driven.
        doReset;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(readVec[i]);
            tick;
            checkOutput($sformatf("rd_cmd[%0d]", i),   32'(cmd),      32'(readVec[i].expCmd));
            checkOutput($sformatf("rd_addr[%0d]", i),  addr,          readVec[i].expAddr);
            checkOutput($sformatf("rd_valid[%0d]", i), 32'(rspValid), 32'(readVec[i].expValid));
            checkOutput($sformatf("rd_rdata[%0d]", i), rspRdata,      readVec[i].expRdata);
        end

        // Reset while waiting for read data: outputs clear at once, no response later.
        reqValid = 1; reqWr = 0; reqAddr = 32'h80;
        tick;
        reqValid = 0;
        tick;
        checkOutput("rst_rd_cmd", 32'(cmd), 32'h1);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        tick;
        tick;
        #2 rst = 1'b1;
        #1 checkResetValues("midrwait");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        checkOutput("ready_after_midrst", 32'(reqReady), 32'h1);
        rDataEnd = 1;
        tick;
        rDataEnd = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            dataOut = 8'(i + 1);
            tick;
            if (rspValid) pulses++;
        end
        dataOut = 0;
        checkOutput("no_rsp_after_reset", 32'(pulses), 32'h0);
        checkOutput("cmd_idle_after_reset", 32'(cmd), 32'h0);

        // Backpressure: five pushes with no ack fill the queue behind the issued one.
        doReset;
        for (int i = 0; i < 5; i++) begin
            reqValid = 1; reqWr = 1; reqAddr = 32'h1000 + 32'(i); reqWdata = 32'(i);
            tick;
            checkOutput($sformatf("bp_ready[%0d]", i), 32'(reqReady), (i < 4) ? 32'h1 : 32'h0);
        end
        checkOutput("bp_cmd",  32'(cmd), 32'h2);
        checkOutput("bp_addr", addr,     32'h1000);
        reqAddr = 32'h2000; reqWdata = 32'h55;
        badCycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (reqReady !== 1'b0 || cmd !== 3'b010) badCycles++;
        end
        checkOutput("bp_full_hold", 32'(badCycles), 32'h0);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        waited = 0;
        early = 0;
        do begin
            tick;
            waited++;
            if (cmd == 3'b000 && reqReady) early++;
        end while (cmd == 3'b000 && waited < 40);
        checkOutput("bp_pop_latency", 32'(waited), 32'd13);
        checkOutput("bp_ready_low_until_pop", 32'(early), 32'h0);
        checkOutput("bp_next_addr", addr, 32'h1001);
        checkOutput("bp_ready_after_pop", 32'(reqReady), 32'h1);
        tick;
        reqValid = 0;
        checkOutput("bp_sixth_accepted_full", 32'(reqReady), 32'h0);

        // Ack timeout on a read.
        doReset;
        reqValid = 1; reqWr = 0; reqAddr = 32'h200;
        tick;
        reqValid = 0;
        tick;
        checkOutput("to_cmd", 32'(cmd), 32'h1);
        badCycles = 0;
        for (int i = 1; i <= 15; i++) begin
            tick;
            if (cmd !== 3'b001 || rspValid !== 1'b0) badCycles++;
        end
        checkOutput("to_wait_cycles", 32'(badCycles), 32'h0);
        tick;
`ifdef SDRAM_HOST_SCHED_TIMEOUT_EN
        checkOutput("to_cmd_abort", 32'(cmd),      32'h0);
        checkOutput("to_valid",     32'(rspValid), 32'h1);
        checkOutput("to_err",       32'(rspErr),   32'h1);
        tick;
        checkOutput("to_valid_end", 32'(rspValid), 32'h0);
`else
        checkOutput("to_cmd_held",  32'(cmd),      32'h1);
        checkOutput("to_no_valid",  32'(rspValid), 32'h0);
        checkOutput("to_err_zero",  32'(rspErr),   32'h0);
        badCycles = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (cmd !== 3'b001 || rspValid !== 1'b0 || rspErr !== 1'b0) badCycles++;
        end
        checkOutput("to_held_forever", 32'(badCycles), 32'h0);
`endif

        // Refresh on the REFRESH_PERIOD=8 instance (edge 1 after reset is consumed by doReset).
        doReset;
        badCycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rCmd !== 3'b000) badCycles++;
        end
        checkOutput("ref_quiet_before_wrap", 32'(badCycles), 32'h0);
        reqValid = 1; reqWr = 0; reqAddr = 32'h80; reqWdata = 32'h0;
        tick;
        reqValid = 0;
        checkOutput("ref_cmd_at_wrap", 32'(rCmd), 32'h0);
        tick;
        checkOutput("ref_first_refresh", 32'(rCmd), 32'h3);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        checkOutput("ref_after_ack", 32'(rCmd), 32'h0);
        tick;
        checkOutput("ref_read_cmd",    32'(rCmd), 32'h1);
        checkOutput("ref_read_addr",   rAddr,     32'h80);
        checkOutput("ref_read_datain", rDatain,   32'h0);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        checkOutput("ref_read_acked", 32'(rCmd), 32'h0);
        badCycles = 0;
        for (int i = 0; i < 7; i++) begin
            tick;
            if (rCmd !== 3'b000) badCycles++;
        end
        rDataEnd = 1;
        tick;
        rDataEnd = 0;
        dataOut = 8'hAA;
        tick;
        for (int i = 1; i <= 4; i++) begin
            dataOut = 8'(i);
            tick;
            if (rCmd !== 3'b000) badCycles++;
        end
        dataOut = 0;
        checkOutput("ref_no_cmd_during_read", 32'(badCycles), 32'h0);
        checkOutput("ref_read_valid", 32'(rRspValid), 32'h1);
        checkOutput("ref_read_rdata", rRspRdata,      32'h0403_0201);
        checkOutput("ref_read_err",   32'(rRspErr),   32'h0);
        tick;
        checkOutput("ref_merged_refresh", 32'(rCmd),      32'h3);
        checkOutput("ref_ready",          32'(rReqReady), 32'h1);
        cmdAck = 1;
        tick;
        cmdAck = 0;
        checkOutput("ref_second_ack", 32'(rCmd), 32'h0);
        badCycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rCmd !== 3'b000) badCycles++;
        end
        checkOutput("ref_only_one_refresh", 32'(badCycles), 32'h0);

        $display("test done: total=%0d bad=%0d", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sdram_host_sched.md
SDRAM_HOST_SCHED -- requirements
Module: sdram_host_sched

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 1560, meaning the CLK cycles between refresh requests.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the host request queue entries (power of 2).
REQ-003 SHALL have parameter WR_HOLD, default 12, meaning the cycles DATAIN is held after CMDACK on a write.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles to wait for CMDACK.
REQ-005 SHALL have port CLK  in  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port RESET_N  in  1  asynchronous reset, active-high; RESET_N=1 resets the block despite the name.
REQ-007 SHALL have port REQ_VALID  in  1  host request valid.
REQ-008 SHALL have port REQ_READY  out  1  queue not full.
REQ-009 SHALL have port REQ_WR  in  1  1=write, 0=read.
REQ-010 SHALL have port REQ_ADDR  in  32  request address.
REQ-011 SHALL have port REQ_WDATA  in  32  write data.
REQ-012 SHALL have port RSP_VALID  out  1  one-cycle completion pulse.
REQ-013 SHALL have port RSP_RDATA  out  32  read data, valid with RSP_VALID on reads.
REQ-014 SHALL have port RSP_ERR  out  1  qualifies RSP_VALID; 1 = ack timeout.
REQ-015 SHALL have port CMD  out  3  controller command: 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH.
REQ-016 SHALL have port ADDR  out  32  controller address.
REQ-017 SHALL have port DATAIN  out  32  controller write data.
REQ-018 SHALL have port CMDACK  in  1  controller command accept.
REQ-019 SHALL have port R_DATAEND  in  1  controller read burst complete.
REQ-020 SHALL have port DATAOUT  in  8  controller read byte stream.

Function
REQ-021 SHALL push {REQ_WR,REQ_ADDR,REQ_WDATA} on a cycle with REQ_VALID&REQ_READY; REQ_READY=0 when FIFO holds FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL implement FSM states IDLE, ISSUE, WHOLD, RWAIT, RCAP, REFACK.
REQ-023 SHALL in IDLE, if refresh pending, go to REFACK driving CMD=011; otherwise, if FIFO non-empty, pop the head and go to ISSUE driving CMD=001/010 with ADDR/DATAIN from the entry; otherwise CMD=000.
REQ-024 SHALL give refresh priority over a queued request when both are present in the same IDLE cycle.
REQ-025 SHALL hold CMD/ADDR/DATAIN stable in ISSUE/REFACK until CMDACK is sampled 1, then drive CMD=000 the next cycle.
REQ-026 SHALL, on write ack, enter WHOLD, keep DATAIN stable WR_HOLD cycles, pulse RSP_VALID=1/RSP_ERR=0 on the last WHOLD cycle, and return to IDLE.
REQ-027 SHALL, on read ack, enter RWAIT until R_DATAEND is sampled 1, then enter RCAP.
REQ-028 SHALL in RCAP sample DATAOUT on the 2nd..5th rising edges after the R_DATAEND edge into bytes 0..3 (byte0 = RSP_RDATA[7:0]), then pulse RSP_VALID with RSP_RDATA the cycle after the 4th byte.
REQ-029 SHALL use a refresh counter 0..REFRESH_PERIOD-1 that wraps and sets a single pending flag on wrap; the flag does not accumulate and is cleared on REFRESH CMDACK; REFRESH completion produces no RSP_VALID.
REQ-030 SHALL count freely during any state, so a wrap during a read/write is serviced at the next IDLE.
REQ-031 SHALL keep RSP_RDATA unchanged except when loaded in RCAP.

Reset
REQ-032 SHALL on RESET_N=1 immediately force CMD=000, ADDR=0, DATAIN=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, REQ_READY=0, FSM=IDLE, FIFO empty, refresh counter=0, pending=0.
REQ-033 SHALL assert REQ_READY=1 the first cycle after RESET_N deasserts; an in-flight command aborted by reset produces no response.

Configuration
REQ-034 SHALL, with macro SDRAM_HOST_SCHED_TIMEOUT_EN defined, abort ISSUE after ACK_TIMEOUT cycles without CMDACK: CMD=000, pulse RSP_VALID=1/RSP_ERR=1, return to IDLE; REFACK timeout drops the refresh and clears pending.
REQ-035 SHALL, without SDRAM_HOST_SCHED_TIMEOUT_EN, wait indefinitely for CMDACK and tie RSP_ERR to 0.

Verification
REQ-036 SHALL verify: write 0x0000_0123 / 0xDEAD_BEEF, CMDACK after 3 cycles -> CMD=010, ADDR=0x123, DATAIN held 12 cycles, one RSP_VALID with RSP_ERR=0.
REQ-037 SHALL verify: read 0x40, R_DATAEND then bytes 0xEF,0xBE,0xAD,0xDE -> RSP_RDATA=0xDEADBEEF with a one-cycle RSP_VALID.
REQ-038 SHALL verify: 5 pushes with no ack -> REQ_READY=0 after the 4th queued entry (one popped into ISSUE), the 5th accepted only after a pop.
REQ-039 SHALL verify: REFRESH_PERIOD=8 with a queued read at wrap -> CMD=011 issued before CMD=001; two wraps during a long read yield exactly one REFRESH.
REQ-040 SHALL verify: with TIMEOUT_EN and CMDACK held 0 -> RSP_VALID&RSP_ERR after 16 cycles, CMD=000; without it, CMD held indefinitely.
REQ-041 SHALL verify: RESET_N=1 mid-RWAIT -> all outputs at reset values in the same cycle, no RSP_VALID afterwards.
